clefia_host_if: RTL
===================

# clefia_host_if

Host-side front end for the `CLEFIA` core. Exposes a 16-bit register-mapped write/read port. Assembles the 256-bit key and 128-bit data block from 16-bit words and sequences the core's KEYSET/DATASET handshakes against BSY. Captures DOUT on DVLD into a readable result buffer, so a narrow host bus can drive the core word-by-word.

## Interface
Parameters:
- none (word width fixed at 16; address width fixed at 6)

Ports:
- CLK  in  1  system clock; every register updates on the rising edge
- SRST  in  1  synchronous, active-high reset
- WE  in  1  host write strobe, one word per cycle
- RE  in  1  host read strobe
- ADDR  in  6  word address
- WDATA  in  16  host write data
- RDATA  out  16  read data, registered
- RVLD  out  1  RDATA valid, one cycle after RE
- IRQ  out  1  level, equals status DONE
- MODE  out  2  to core; 00 = 128-bit key, 01 = 192-bit, 10 = 256-bit
- ENCDEC  out  1  to core; 0 = encrypt, 1 = decrypt
- KEYSET  out  1  to core; one-cycle pulse
- DATASET  out  1  to core; one-cycle pulse
- KEY  out  256  to core, direct from the key register
- DIN  out  128  to core, direct from the data register
- BSY  in  1  from core
- DVLD  in  1  from core
- DOUT  in  128  from core

## Operation
Address map:
- 0x00–0x0F: key word i → KEY[16i+15:16i]. 128-bit keys use words 0–7; 192-bit keys use 0–11. Keys are right-justified.
- 0x10–0x17: data word j → DIN[16j+15:16j].
- 0x18 CMD (write):
  - bit0 START_KEY
  - bit1 START_DATA
  - bits[3:2] MODE
  - bit4 ENCDEC
- 0x19 STATUS (read): bit0 BUSY, bit1 KEY_VALID, bit2 DONE, bit3 ERR. Reading STATUS clears DONE and ERR.
- 0x20–0x27: result word j = RES[16j+15:16j].
- Reads of unmapped addresses return 0x0000. Writes to unmapped addresses are ignored.

FSM states: IDLE, K_ISSUE, K_WAITHI, K_WAITLO, D_ISSUE, D_WAITHI, D_WAITLO.
- IDLE + CMD write with START_KEY=1 → latch MODE, ENCDEC → K_ISSUE.
- K_ISSUE: KEYSET=1 for exactly one cycle → K_WAITHI.
- K_WAITHI: stay until BSY=1 → K_WAITLO.
- K_WAITLO: stay until BSY=0 → set KEY_VALID → IDLE.
- IDLE + START_DATA=1 with KEY_VALID=1 → latch ENCDEC → D_ISSUE.
- D_ISSUE: DATASET=1 for one cycle → D_WAITHI.
- D_WAITHI: stay until BSY=1 → D_WAITLO.
- D_WAITLO: stay until BSY=0 → IDLE.
- DVLD=1 in any state → RES ← DOUT, DONE ← 1.
- START_KEY and START_DATA both set → START_KEY is taken; START_DATA is dropped and ERR ← 1.
- START_DATA with KEY_VALID=0 → ignored, ERR ← 1.
- MODE in the CMD word is ignored for START_DATA; the MODE latched at key load stays on the port.
- START_KEY clears KEY_VALID on acceptance.
- BUSY = (state ≠ IDLE).
- While BUSY:
  - writes to 0x00–0x18 are ignored and set ERR.
  - KEY, DIN, MODE and ENCDEC stay stable.
- Reads are allowed at any time.
- MODE = 11 on START_KEY → ignored, ERR ← 1.

## Timing
- Reset values:
  - RDATA=0, RVLD=0, IRQ=0
  - MODE=00, ENCDEC=0, KEYSET=0, DATASET=0
  - KEY=0, DIN=0, RES=0
  - all STATUS bits 0, state IDLE
- Write to a key or data register is visible on KEY/DIN the next cycle.
- CMD write in cycle t → KEYSET or DATASET high in cycle t+1, low in t+2.
- Read: RE in cycle t → RDATA and RVLD valid in t+1. RVLD is otherwise 0.
- Same cycle as a STATUS read:
  - DVLD and a STATUS read together → DONE ends set (set wins).
  - An error event and a STATUS read together → ERR ends set.
- SRST mid-operation aborts to IDLE, clears KEY_VALID, and deasserts KEYSET/DATASET the next cycle. The core must be reset by the same SRST.
- WE and RE in the same cycle are both serviced.

## Test plan
- Key schedule:
  - Write key words 0–7 = 0x1100, 0x3322, …, 0xffee.
  - Write CMD = 0x0001.
  - Expect one KEYSET pulse with KEY[127:0] = ffeeddccbbaa99887766554433221100.
  - After BSY falls, STATUS = 0x2.
- Encrypt:
  - Write data words for 000102030405060708090a0b0c0d0e0f.
  - Write CMD = 0x0002.
  - Expect a DATASET pulse, then DONE and IRQ.
  - Result words 0x20–0x27 read de2bf2fd9b74aacdf1298555459494fd.
- Decrypt:
  - Load that ciphertext and write CMD = 0x0012 (START_DATA, ENCDEC=1).
  - Result reads 000102030405060708090a0b0c0d0e0f.
- Errors:
  - START_DATA after reset → no DATASET pulse, STATUS = 0x8.
  - A key-word write during BUSY → KEY unchanged, ERR set.
  - CMD = 0x000D (START_KEY with MODE=11) → no KEYSET pulse, ERR set.
- Read-clear race:
  - STATUS read in the same cycle as DVLD → that read returns DONE=0.
  - The next STATUS read returns DONE=1.
- Reset abort:
  - Assert SRST while in D_WAITLO.
  - Next cycle: state IDLE, STATUS = 0, KEYSET = DATASET = 0, IRQ = 0.

Source files
------------

// File: rtl/clefia_host_if.sv
// Host-side front end for the CLEFIA core: a 16-bit word-mapped register port that
// assembles key/data blocks, sequences KEYSET/DATASET against BSY and buffers DOUT.
module clefia_host_if (
  input  logic         CLK,
  input  logic         SRST,
  input  logic         WE,
  input  logic         RE,
  input  logic [5:0]   ADDR,
  input  logic [15:0]  WDATA,
  output logic [15:0]  RDATA,
  output logic         RVLD,
  output logic         IRQ,
  output logic [1:0]   MODE,
  output logic         ENCDEC,
  output logic         KEYSET,
  output logic         DATASET,
  output logic [255:0] KEY,
  output logic [127:0] DIN,
  input  logic         BSY,
  input  logic         DVLD,
  input  logic [127:0] DOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_K_ISSUE,
    S_K_WAITHI,
    S_K_WAITLO,
    S_D_ISSUE,
    S_D_WAITHI,
    S_D_WAITLO
  } state_t;

  localparam logic [5:0] A_CMD    = 6'h18;
  localparam logic [5:0] A_STATUS = 6'h19;

  state_t         r_state;
  logic [255:0]   r_key;
  logic [127:0]   r_din;
  logic [127:0]   r_res;
  logic           r_key_valid;
  logic           r_done;
  logic           r_err;
  logic [1:0]     r_mode;
  logic           r_encdec;
  logic           r_keyset;
  logic           r_dataset;
  logic [15:0]    r_rdata;
  logic           r_rvld;

  logic           w_busy;
  logic           w_wr_key;
  logic           w_wr_data;
  logic           w_wr_cmd;
  logic           w_wr_ctl;
  logic           w_rd_status;
  logic           w_cmd_ok;
  logic           w_cmd_key;
  logic           w_cmd_data;
  logic           w_bad_mode;
  logic           w_start_key;
  logic           w_start_data;
  logic           w_err_evt;
  logic [15:0]    w_rdata;

  function automatic logic [15:0] f_status(input logic busy, input logic kv,
                                           input logic done, input logic err);
    return {12'd0, err, done, kv, busy};
  endfunction

  assign w_busy      = (r_state != S_IDLE);
  assign w_wr_key    = WE && (ADDR[5:4] == 2'b00);
  assign w_wr_data   = WE && (ADDR[5:3] == 3'b010);
  assign w_wr_cmd    = WE && (ADDR == A_CMD);
  assign w_wr_ctl    = w_wr_key || w_wr_data || w_wr_cmd;
  assign w_rd_status = RE && (ADDR == A_STATUS);

  // START_KEY has priority; a simultaneous START_DATA is dropped and flagged.
  assign w_cmd_ok     = w_wr_cmd && !w_busy;
  assign w_cmd_key    = w_cmd_ok && WDATA[0];
  assign w_cmd_data   = w_cmd_ok && WDATA[1];
  assign w_bad_mode   = (WDATA[3:2] == 2'b11);
  assign w_start_key  = w_cmd_key && !w_bad_mode;
  assign w_start_data = w_cmd_data && !WDATA[0] && r_key_valid;
  assign w_err_evt    = (w_wr_ctl && w_busy)
                     || (w_cmd_key && w_bad_mode)
                     || (w_cmd_key && w_cmd_data)
                     || (w_cmd_data && !WDATA[0] && !r_key_valid);

  always_comb begin
    w_rdata = '0;
    if (ADDR[5:4] == 2'b00) begin
      for (int i = 0; i < 16; i++)
        if (ADDR[3:0] == 4'(i)) w_rdata = r_key[16*i +: 16];
    end else if (ADDR[5:3] == 3'b010) begin
      for (int j = 0; j < 8; j++)
        if (ADDR[2:0] == 3'(j)) w_rdata = r_din[16*j +: 16];
    end else if (ADDR == A_STATUS) begin
      w_rdata = f_status(w_busy, r_key_valid, r_done, r_err);
    end else if (ADDR[5:3] == 3'b100) begin
      for (int j = 0; j < 8; j++)
        if (ADDR[2:0] == 3'(j)) w_rdata = r_res[16*j +: 16];
    end
  end

  // Key/data words only accept writes while idle so the core sees stable operands.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_key <= '0;
      r_din <= '0;
    end else if (!w_busy) begin
      if (w_wr_key) begin
        for (int i = 0; i < 16; i++)
          if (ADDR[3:0] == 4'(i)) r_key[16*i +: 16] <= WDATA;
      end
      if (w_wr_data) begin
        for (int j = 0; j < 8; j++)
          if (ADDR[2:0] == 3'(j)) r_din[16*j +: 16] <= WDATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_rdata <= '0;
      r_rvld  <= 1'b0;
    end else begin
      r_rvld <= RE;
      if (RE) r_rdata <= w_rdata;
    end
  end

  // Sticky flags: a set event in the same cycle as the clearing STATUS read wins.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_res  <= '0;
    end else begin
      r_done <= DVLD || (r_done && !w_rd_status);
      r_err  <= w_err_evt || (r_err && !w_rd_status);
      if (DVLD) r_res <= DOUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_state     <= S_IDLE;
      r_key_valid <= 1'b0;
      r_mode      <= 2'b00;
      r_encdec    <= 1'b0;
      r_keyset    <= 1'b0;
      r_dataset   <= 1'b0;
    end else begin
      r_keyset  <= 1'b0;
      r_dataset <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_key) begin
            r_mode      <= WDATA[3:2];
            r_encdec    <= WDATA[4];
            r_key_valid <= 1'b0;
            r_keyset    <= 1'b1;
            r_state     <= S_K_ISSUE;
          end else if (w_start_data) begin
            r_encdec  <= WDATA[4];
            r_dataset <= 1'b1;
            r_state   <= S_D_ISSUE;
          end
        end
        S_K_ISSUE:  r_state <= S_K_WAITHI;
        S_K_WAITHI: if (BSY) r_state <= S_K_WAITLO;
        S_K_WAITLO: begin
          if (!BSY) begin
            r_key_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_D_ISSUE:  r_state <= S_D_WAITHI;
        S_D_WAITHI: if (BSY) r_state <= S_D_WAITLO;
        S_D_WAITLO: if (!BSY) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign RDATA   = r_rdata;
  assign RVLD    = r_rvld;
  assign IRQ     = r_done;
  assign MODE    = r_mode;
  assign ENCDEC  = r_encdec;
  assign KEYSET  = r_keyset;
  assign DATASET = r_dataset;
  assign KEY     = r_key;
  assign DIN     = r_din;

endmodule
